// File: rtl/burst_mem_slave.sv
// Burst memory slave that serves fixed-length INCR/WRAP read and write bursts over valid/ready channels.
// Storage is a plain word array; out-of-range bursts run their full length but never touch storage.
module burst_mem_slave #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_WORDS       = 128,
  parameter int READ_BURST_LEN  = 8,
  parameter int WRITE_BURST_LEN = 8,
  parameter int READ_LATENCY    = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic                    req_wrap,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_err,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdata_last,
  output logic                    rdata_err
);

  localparam int NBytes  = DATA_WIDTH / 8;
  localparam int OffBits = (NBytes > 1) ? $clog2(NBytes) : 0;
  localparam int MaxLen  = (READ_BURST_LEN > WRITE_BURST_LEN) ? READ_BURST_LEN : WRITE_BURST_LEN;
  localparam int CW      = $clog2(MaxLen) + 1;
  localparam int LW      = $clog2(READ_LATENCY) + 1;
  localparam int MW      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int AW1     = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, RD_LAT, RD_BURST, WR_BURST, WR_RESP} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    wrap_q, wrap_d;
  logic                    write_q, write_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           beat_q, beat_d;
  logic [LW-1:0]           lat_q, lat_d;

  logic [DATA_WIDTH-1:0]   mem [NUM_WORDS];

  logic [ADDR_WIDTH-1:0]   reqIdx, reqLenM1;
  logic [AW1-1:0]          reqIncrEnd;
  logic                    reqErr;
  logic [ADDR_WIDTH-1:0]   lenM1, incrAddr, beatAddr;
  logic                    inRange;
  logic [MW-1:0]           memIdx;
  logic                    memWe;

  // Error is decided once at request time from the start index and the direction's burst length.
  always_comb begin
    reqIdx     = req_addr >> OffBits;
    reqLenM1   = req_write ? ADDR_WIDTH'(WRITE_BURST_LEN - 1) : ADDR_WIDTH'(READ_BURST_LEN - 1);
    reqIncrEnd = {1'b0, reqIdx} + {1'b0, reqLenM1} + AW1'(1);
    if (req_wrap) reqErr = {1'b0, reqIdx | reqLenM1} >= AW1'(NUM_WORDS);
    else          reqErr = reqIncrEnd > AW1'(NUM_WORDS);
  end

  always_comb begin
    lenM1    = write_q ? ADDR_WIDTH'(WRITE_BURST_LEN - 1) : ADDR_WIDTH'(READ_BURST_LEN - 1);
    incrAddr = idx_q + ADDR_WIDTH'(beat_q);
    beatAddr = wrap_q ? ((idx_q & ~lenM1) | (incrAddr & lenM1)) : incrAddr;
    inRange  = beatAddr < ADDR_WIDTH'(NUM_WORDS);
    memIdx   = beatAddr[MW-1:0];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      write_q <= write_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wrap_d      = wrap_q;
    write_d     = write_q;
    err_d       = err_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    rdata_valid = 1'b0;
    rdata       = '0;
    rdata_last  = 1'b0;
    rdata_err   = 1'b0;
    memWe       = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          idx_d   = reqIdx;
          wrap_d  = req_wrap;
          write_d = req_write;
          err_d   = reqErr;
          beat_d  = '0;
          lat_d   = '0;
          if (req_write)              state_d = WR_BURST;
          else if (READ_LATENCY == 1) state_d = RD_BURST;
          else                        state_d = RD_LAT;
        end
      end
      RD_LAT: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LW'(READ_LATENCY - 2)) state_d = RD_BURST;
      end
      RD_BURST: begin
        rdata_valid = 1'b1;
        rdata_err   = err_q;
        rdata_last  = beat_q == CW'(READ_BURST_LEN - 1);
        if (!err_q && inRange) rdata = mem[memIdx];
        if (rdata_ready) begin
          beat_d = beat_q + CW'(1);
          if (rdata_last) state_d = IDLE;
        end
      end
      WR_BURST: begin
        wdata_ready = 1'b1;
        if (wdata_valid) begin
          memWe  = !err_q && inRange;
          beat_d = beat_q + CW'(1);
          if (beat_q == CW'(WRITE_BURST_LEN - 1)) state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage has no reset; memWe is gated by the reset FSM so an abandoned burst stops writing at once.
  always_ff @(posedge sys_clk) begin
    if (memWe) begin
      for (int b = 0; b < NBytes; b++) begin
        if (wstrb[b]) mem[memIdx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_mem_slave.sv
// Directed bench for burst_mem_slave with the default 32-bit, 128-word, 8-beat, latency-2 configuration.
module tb_burst_mem_slave;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        req_valid, req_ready, req_write, req_wrap;
  logic [31:0] req_addr;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        resp_valid, resp_ready, resp_err;
  logic        rdata_valid, rdata_ready, rdata_last, rdata_err;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] wd [8];
  logic [3:0]  ws [8];
  logic [31:0] rd [8];
  logic        rl [8];
  logic        re [8];
  int          rcount, rlat;
  logic        rtmo, rstableBad, rextra;

  burst_mem_slave dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_wrap    (req_wrap),
    .req_addr    (req_addr),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_err    (resp_err),
    .rdata_valid (rdata_valid),
    .rdata_ready (rdata_ready),
    .rdata       (rdata),
    .rdata_last  (rdata_last),
    .rdata_err   (rdata_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_wrap    = 1'b0;
    req_addr    = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    resp_ready  = 1'b0;
    rdata_ready = 1'b0;
  endtask

  // Runs one full 8-beat write burst from wd/ws and returns the response error flag.
  task automatic write_burst(input logic [31:0] addr, input logic wrap, output logic err, output logic tmo);
    int guard;
    tmo = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_wrap = wrap; req_addr = addr;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge sys_clk); #1; guard++; end
    if (!req_ready) tmo = 1'b1;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 8; n++) begin
      wdata_valid = 1'b1; wdata = wd[n]; wstrb = ws[n];
      guard = 0;
      while (!wdata_ready && guard < 50) begin @(posedge sys_clk); #1; guard++; end
      if (!wdata_ready) tmo = 1'b1;
      @(posedge sys_clk); #1;
    end
    wdata_valid = 1'b0;
    resp_ready = 1'b1;
    guard = 0;
    while (!resp_valid && guard < 50) begin @(posedge sys_clk); #1; guard++; end
    if (!resp_valid) tmo = 1'b1;
    err = resp_err;
    @(posedge sys_clk); #1;
    resp_ready = 1'b0;
  endtask

  // Runs one read burst, optionally stalling beat stallBeat for stallCycles cycles; results land in rd/rl/re.
  task automatic read_burst(input logic [31:0] addr, input logic wrap, input int stallBeat, input int stallCycles);
    int guard, cyc, stallLeft;
    logic [33:0] snap;
    rtmo = 1'b0; rstableBad = 1'b0; rcount = 0; snap = '0;
    req_valid = 1'b1; req_write = 1'b0; req_wrap = wrap; req_addr = addr;
    guard = 0;
    while (!req_ready && guard < 50) begin @(posedge sys_clk); #1; guard++; end
    if (!req_ready) rtmo = 1'b1;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    rlat = 1;
    while (!rdata_valid && rlat < 40) begin @(posedge sys_clk); #1; rlat++; end
    if (!rdata_valid) rtmo = 1'b1;
    stallLeft = stallCycles;
    cyc = 0;
    while (rcount < 8 && cyc < 100) begin
      if (rdata_valid) begin
        if (rcount == stallBeat && stallLeft > 0) begin
          if (stallLeft == stallCycles) snap = {rdata, rdata_last, rdata_err};
          else if ({rdata, rdata_last, rdata_err} !== snap) rstableBad = 1'b1;
          rdata_ready = 1'b0;
          stallLeft--;
        end else begin
          if (rcount == stallBeat && stallCycles > 0 && {rdata, rdata_last, rdata_err} !== snap)
            rstableBad = 1'b1;
          rdata_ready = 1'b1;
          rd[rcount] = rdata; rl[rcount] = rdata_last; re[rcount] = rdata_err;
          rcount++;
        end
      end else begin
        rdata_ready = 1'b0;
      end
      @(posedge sys_clk); #1;
      cyc++;
    end
    if (rcount < 8) rtmo = 1'b1;
    rdata_ready = 1'b0;
    rextra = rdata_valid;
  endtask

  task automatic test_reset();
    idle_inputs();
    sys_rst_n = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if ({wdata_ready, resp_valid, resp_err, rdata_valid, rdata_last, rdata_err} !== 6'b0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected 000000",
                         {wdata_ready, resp_valid, resp_err, rdata_valid, rdata_last, rdata_err});
    end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
  endtask

  task automatic test_incr_write_read();
    logic err, tmo;
    for (int n = 0; n < 8; n++) begin wd[n] = 32'h100 + 32'(n); ws[n] = 4'hF; end
    write_burst(32'h0, 1'b0, err, tmo);
    checks++; if (tmo !== 1'b0) begin errors++; $display("[TB] FAIL incr_write_timeout: got %b expected 0", tmo); end
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL incr_write_resp_err: got %b expected 0", err); end
    read_burst(32'h0, 1'b0, -1, 0);
    checks++; if (rtmo !== 1'b0) begin errors++; $display("[TB] FAIL incr_read_timeout: got %b expected 0", rtmo); end
    checks++; if (rlat !== 2) begin errors++; $display("[TB] FAIL incr_read_latency: got %0d expected 2", rlat); end
    for (int n = 0; n < 8; n++) begin
      checks++; if ({rd[n], rl[n], re[n]} !== {32'h100 + 32'(n), n == 7, 1'b0}) begin
        errors++; $display("[TB] FAIL incr_read_beat%0d: got %h/%b/%b expected %h/%b/0", n, rd[n], rl[n], re[n], 32'h100 + 32'(n), n == 7);
      end
    end
    checks++; if (rextra !== 1'b0) begin errors++; $display("[TB] FAIL incr_read_extra_beat: got %b expected 0", rextra); end
  endtask

  task automatic test_wrap_read();
    int widx [8] = '{5, 6, 7, 0, 1, 2, 3, 4};
    read_burst(32'h14, 1'b1, -1, 0);
    checks++; if (rtmo !== 1'b0) begin errors++; $display("[TB] FAIL wrap_read_timeout: got %b expected 0", rtmo); end
    for (int n = 0; n < 8; n++) begin
      checks++; if ({rd[n], rl[n], re[n]} !== {32'h100 + 32'(widx[n]), n == 7, 1'b0}) begin
        errors++; $display("[TB] FAIL wrap_read_beat%0d: got %h/%b/%b expected %h/%b/0", n, rd[n], rl[n], re[n], 32'h100 + 32'(widx[n]), n == 7);
      end
    end
  endtask

  task automatic test_strobe();
    logic err, tmo;
    logic [31:0] exp;
    for (int n = 0; n < 8; n++) begin wd[n] = 32'h200 + 32'(n); ws[n] = 4'hF; end
    wd[0] = 32'h11223344;
    write_burst(32'h40, 1'b0, err, tmo);
    for (int n = 0; n < 8; n++) begin wd[n] = 32'hFFFFFFFF; ws[n] = 4'h0; end
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    write_burst(32'h40, 1'b0, err, tmo);
    checks++; if ({tmo, err} !== 2'b00) begin errors++; $display("[TB] FAIL strobe_write: got tmo/err %b expected 00", {tmo, err}); end
    read_burst(32'h40, 1'b0, -1, 0);
    for (int n = 0; n < 8; n++) begin
      exp = (n == 0) ? 32'h11BB33DD : 32'h200 + 32'(n);
      checks++; if (rd[n] !== exp) begin errors++; $display("[TB] FAIL strobe_beat%0d: got %h expected %h", n, rd[n], exp); end
    end
  endtask

  task automatic test_backpressure();
    read_burst(32'h0, 1'b0, 3, 4);
    checks++; if (rcount !== 8) begin errors++; $display("[TB] FAIL bp_beat_count: got %0d expected 8", rcount); end
    checks++; if (rstableBad !== 1'b0) begin errors++; $display("[TB] FAIL bp_stable: got unstable=%b expected 0", rstableBad); end
    checks++; if (rextra !== 1'b0) begin errors++; $display("[TB] FAIL bp_extra_beat: got %b expected 0", rextra); end
    for (int n = 0; n < 8; n++) begin
      checks++; if ({rd[n], rl[n]} !== {32'h100 + 32'(n), n == 7}) begin
        errors++; $display("[TB] FAIL bp_beat%0d: got %h/%b expected %h/%b", n, rd[n], rl[n], 32'h100 + 32'(n), n == 7);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic err, tmo;
    int widx [8] = '{124, 125, 126, 127, 120, 121, 122, 123};
    for (int n = 0; n < 8; n++) begin wd[n] = 32'h500 + 32'(n); ws[n] = 4'hF; end
    write_burst(32'h1E0, 1'b0, err, tmo);
    checks++; if ({tmo, err} !== 2'b00) begin errors++; $display("[TB] FAIL oor_edge_write: got tmo/err %b expected 00", {tmo, err}); end
    read_burst(32'h1F0, 1'b0, -1, 0);
    checks++; if (rtmo !== 1'b0) begin errors++; $display("[TB] FAIL oor_read_timeout: got %b expected 0", rtmo); end
    for (int n = 0; n < 8; n++) begin
      checks++; if ({rd[n], rl[n], re[n]} !== {32'h0, n == 7, 1'b1}) begin
        errors++; $display("[TB] FAIL oor_read_beat%0d: got %h/%b/%b expected 0/%b/1", n, rd[n], rl[n], re[n], n == 7);
      end
    end
    for (int n = 0; n < 8; n++) wd[n] = 32'hDEAD0000 + 32'(n);
    write_burst(32'h1F0, 1'b0, err, tmo);
    checks++; if ({tmo, err} !== 2'b01) begin errors++; $display("[TB] FAIL oor_write_resp_err: got tmo/err %b expected 01", {tmo, err}); end
    read_burst(32'h1E0, 1'b0, -1, 0);
    for (int n = 0; n < 8; n++) begin
      checks++; if ({rd[n], re[n]} !== {32'h500 + 32'(n), 1'b0}) begin
        errors++; $display("[TB] FAIL oor_mem_unchanged%0d: got %h/%b expected %h/0", n, rd[n], re[n], 32'h500 + 32'(n));
      end
    end
    read_burst(32'h1F0, 1'b1, -1, 0);
    for (int n = 0; n < 8; n++) begin
      checks++; if ({rd[n], re[n]} !== {32'h500 + 32'(widx[n] - 120), 1'b0}) begin
        errors++; $display("[TB] FAIL wrap_edge_beat%0d: got %h/%b expected %h/0", n, rd[n], re[n], 32'h500 + 32'(widx[n] - 120));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic err, tmo;
    logic [31:0] exp;
    for (int n = 0; n < 8; n++) begin wd[n] = 32'h300 + 32'(n); ws[n] = 4'hF; end
    write_burst(32'h60, 1'b0, err, tmo);
    req_valid = 1'b1; req_write = 1'b1; req_wrap = 1'b0; req_addr = 32'h60;
    @(posedge sys_clk); #1;
    req_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      wdata_valid = 1'b1; wdata = 32'h400 + 32'(n); wstrb = 4'hF;
      @(posedge sys_clk); #1;
    end
    wdata_valid = 1'b1; wdata = 32'h403;
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++; if ({req_ready, wdata_ready, resp_valid, rdata_valid} !== 4'b1000) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b expected 1000", {req_ready, wdata_ready, resp_valid, rdata_valid});
    end
    wdata_valid = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_req_ready: got %b expected 1", req_ready); end
    read_burst(32'h60, 1'b0, -1, 0);
    checks++; if (rtmo !== 1'b0) begin errors++; $display("[TB] FAIL midreset_read_timeout: got %b expected 0", rtmo); end
    for (int n = 0; n < 8; n++) begin
      exp = (n < 3) ? 32'h400 + 32'(n) : 32'h300 + 32'(n);
      checks++; if ({rd[n], rl[n]} !== {exp, n == 7}) begin
        errors++; $display("[TB] FAIL midreset_beat%0d: got %h/%b expected %h/%b", n, rd[n], rl[n], exp, n == 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incr_write_read();
    test_wrap_read();
    test_strobe();
    test_backpressure();
    test_out_of_range();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_mem_slave.md
Name: burst_mem_slave

Overview:
- Parametrised single-clock burst memory slave serving fixed-length read and write bursts over valid/ready channels.
- Successor to the plain instruction/data memory models used under the chip-level bench, generalised with:
  - independent read and write burst lengths,
  - INCR and WRAP address modes,
  - programmable read latency,
  - byte strobes,
  - out-of-range error signalling.
- Sits between a cache/bus master and backing storage on the sys_clk domain.

Parameters:
- DATA_WIDTH, 32, data beat width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- NUM_WORDS, 128, storage depth in DATA_WIDTH words.
- READ_BURST_LEN, 8, beats per read burst; power of two, at least 1.
- WRITE_BURST_LEN, 8, beats per write burst; power of two, at least 1.
- READ_LATENCY, 2, cycles from request handshake to first read beat; at least 1.

Ports:
- sys_clk, input, 1, clock; all logic on rising edge.
- sys_rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, burst request valid.
- req_ready, output, 1, slave accepts request.
- req_write, input, 1, 1 = write burst, 0 = read burst.
- req_wrap, input, 1, 1 = WRAP mode, 0 = INCR mode.
- req_addr, input, ADDR_WIDTH, byte start address; low log2(DATA_WIDTH/8) bits ignored.
- wdata_valid, input, 1, write beat valid.
- wdata_ready, output, 1, write beat accepted.
- wdata, input, DATA_WIDTH, write beat data.
- wstrb, input, DATA_WIDTH/8, byte enables.
- resp_valid, output, 1, write response valid.
- resp_ready, input, 1, master accepts write response.
- resp_err, output, 1, write burst error flag.
- rdata_valid, output, 1, read beat valid.
- rdata_ready, input, 1, master accepts read beat.
- rdata, output, DATA_WIDTH, read beat data.
- rdata_last, output, 1, final beat of the read burst.
- rdata_err, output, 1, per-beat error flag.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - FSM goes to IDLE.
  - req_ready=1; all other outputs 0; beat and latency counters cleared.
  - Storage array is not reset.
  - Reset mid-burst abandons the burst with no response and no further writes.
- FSM states: IDLE, RD_LAT, RD_BURST, WR_BURST, WR_RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch word index, mode, direction and error flag.
  - Read goes to RD_LAT; write goes to WR_BURST.
  - req_ready is 0 in every other state.
- Word index idx = req_addr >> log2(DATA_WIDTH/8). Beat n address:
  - INCR: idx+n.
  - WRAP: (idx & ~(LEN-1)) | ((idx+n) & (LEN-1)), where LEN is the direction's burst length.
- Error:
  - INCR: set at request time if idx+LEN > NUM_WORDS.
  - WRAP: set at request time if (idx | (LEN-1)) >= NUM_WORDS.
  - An erroring burst still runs all LEN beats. Writes are suppressed; reads return 0 with rdata_err=1.
- RD_LAT: count READ_LATENCY-1 cycles, then RD_BURST. The first rdata_valid is asserted exactly READ_LATENCY cycles after the request handshake.
- RD_BURST:
  - rdata, rdata_err and rdata_last are held stable while rdata_valid&&!rdata_ready.
  - The beat advances on handshake.
  - rdata_last=1 on beat LEN-1; its handshake returns to IDLE.
  - Back-to-back beats when rdata_ready is held high: one beat per cycle.
- WR_BURST:
  - wdata_ready=1.
  - Each wdata_valid&&wdata_ready beat writes the bytes selected by wstrb to beat n's address (unless error).
  - The write is visible to a read request accepted the cycle after.
  - After beat LEN-1, go to WR_RESP.
  - No wlast input; the slave counts beats itself.
- WR_RESP: resp_valid=1 and resp_err=latched error, held until resp_ready; then IDLE.
- Bursts never overlap.
- wdata_valid in non-write states is ignored (wdata_ready=0).
- Counters are sized to log2(max(LEN))+1 bits; no overflow at LEN=1.
- With LEN=1, rdata_last is set on the only beat.

Test Plan:
- INCR write then read: write burst at addr 0x00 with data 0x100..0x107 and wstrb=0xF, then read at 0x00 → resp_err=0; 8 read beats return 0x100..0x107; rdata_last on beat 7; first rdata_valid 2 cycles after the request handshake.
- WRAP read: read at addr 0x14 (idx 5) with req_wrap=1 → beats come from word indices 5,6,7,0,1,2,3,4; rdata_last on index 4.
- Byte strobe: write 0xAABBCCDD with wstrb=0x5 over a word holding 0x11223344 → reads back 0x11BB33DD.
- Backpressure: hold rdata_ready low on beat 3 for 4 cycles → rdata stays stable; no beat is lost or duplicated; the total still equals 8 beats.
- Out-of-range: INCR read at idx 124 (addr 0x1F0) with NUM_WORDS=128 → 8 beats of rdata=0 with rdata_err=1. A write to the same address gives resp_err=1 and leaves memory unchanged.
- Reset mid-burst: assert sys_rst_n low during write beat 3 → outputs go to reset values immediately; after release req_ready=1; a new read burst completes normally.
